// File: rtl/mem_request_ctrl.sv
// Memory request controller: turns front-panel I/O requests into valid/ready word commands.
// Optional read-response timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_request_ctrl #(
  parameter int unsigned         ADDR_W         = 25,
  parameter int unsigned         DATA_W         = 16,
  parameter logic [ADDR_W-1:0]   CLEAR_LAST     = '1,
  parameter int unsigned         TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_done,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] io_data,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_err,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata
);

  localparam logic [1:0] ModeClear = 2'b00;
  localparam logic [1:0] ModeRead  = 2'b01;
  localparam logic [1:0] ModeWrite = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    CLEAR    = 2'd3
  } stateT;

  stateT             state;
  logic              ioDoneQ;
  logic [ADDR_W-1:0] clrCnt;
  logic              reqEdge;

  // A request is the rising edge of the I/O controller's done level.
  assign reqEdge = io_done & ~ioDoneQ;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] TmoPattern = DATA_W'(16'hDEAD);

  logic [TMO_W-1:0] tmoCnt;
`else
  assign mem_err = 1'b0;
`endif

  // Request FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ioDoneQ   <= 1'b0;
      clrCnt    <= '0;
      mem_done  <= 1'b1;
      mem_out   <= '0;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
      mem_err   <= 1'b0;
      tmoCnt    <= '0;
`endif
    end else begin
      ioDoneQ <= io_done;
      unique case (state)
        IDLE: begin
          if (reqEdge) begin
            unique case (mode)
              ModeWrite, ModeRead: begin
                state     <= ISSUE;
                mem_done  <= 1'b0;
                cmd_valid <= 1'b1;
                cmd_write <= (mode == ModeWrite);
                cmd_addr  <= mem_addr;
                cmd_wdata <= io_data;
              end
              ModeClear: begin
                state     <= CLEAR;
                mem_done  <= 1'b0;
                clrCnt    <= '0;
                cmd_valid <= 1'b1;
                cmd_write <= 1'b1;
                cmd_addr  <= '0;
                cmd_wdata <= '0;
              end
              default: ;
            endcase
          end
        end

        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (cmd_write) begin
              // Writes are posted: no response is awaited.
              state    <= IDLE;
              mem_done <= 1'b1;
            end else begin
              state <= WAIT_RSP;
`ifdef MEM_TIMEOUT_EN
              tmoCnt <= '0;
`endif
            end
          end
        end

        WAIT_RSP: begin
          if (rsp_valid) begin
            state    <= IDLE;
            mem_done <= 1'b1;
            mem_out  <= rsp_rdata;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmoCnt == TmoLast) begin
            state    <= IDLE;
            mem_done <= 1'b1;
            mem_out  <= TmoPattern;
            mem_err  <= 1'b1;
          end else begin
            tmoCnt <= tmoCnt + TMO_W'(1);
          end
`endif
        end

        CLEAR: begin
          if (cmd_ready) begin
            // Sweep stops on the last address; the counter never wraps.
            if (clrCnt == CLEAR_LAST) begin
              state     <= IDLE;
              mem_done  <= 1'b1;
              cmd_valid <= 1'b0;
            end else begin
              clrCnt   <= clrCnt + ADDR_W'(1);
              cmd_addr <= clrCnt + ADDR_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
